// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received-word ready/valid channel of uart_rx_param
// master drives the held word and its flags; slave returns out_ready.
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 frame_err;
   logic                 parity_err;

   modport master (
      output out_data, out_valid, frame_err, parity_err,
      input  out_ready
   );

   modport slave (
      input  out_data, out_valid, frame_err, parity_err,
      output out_ready
   );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with one-entry holding register
// Optional UART_RX_MAJORITY_EN: 3-tap majority vote at every sample point.
module uart_rx_param #(
   parameter int CLK_DIV   = 435,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             uart_in,
   uart_rx_param_if.master  m_if,
   output logic             overrun,
   output logic             busy
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] FULL_RELOAD = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV / 2 - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   logic [1:0]           sync_q;
   logic                 rxs;
   logic                 rxs_prev_q;
   logic                 sample_bit;
   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic [3:0]           bits_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 perr_q;
   logic                 ferr_q;
   logic                 busy_q;
   logic                 overrun_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 fe_q;
   logic                 pe_q;
   logic                 tick_d;
   logic                 stop_fe_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q     <= 2'b11;
         rxs_prev_q <= 1'b1;
      end else begin
         sync_q     <= {sync_q[0], uart_in};
         rxs_prev_q <= sync_q[1];
      end
   end

   assign rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] tap_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tap_q <= 2'b11;
      else       tap_q <= {tap_q[0], rxs};
   end

   assign sample_bit = (rxs & tap_q[0]) | (rxs & tap_q[1]) | (tap_q[0] & tap_q[1]);
`else
   assign sample_bit = rxs;
`endif

   assign tick_d    = (cnt_q == '0);
   assign stop_fe_d = ferr_q | ~sample_bit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bits_q    <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         fe_q      <= 1'b0;
         pe_q      <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (valid_q && m_if.out_ready) valid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (rxs_prev_q && !rxs) begin
                  cnt_q   <= HALF_RELOAD;
                  state_q <= S_START;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (!tick_d) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (sample_bit) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= S_DATA;
                  cnt_q   <= FULL_RELOAD;
                  bits_q  <= 4'(DATA_BITS - 1);
                  par_q   <= 1'b0;
                  perr_q  <= 1'b0;
                  ferr_q  <= 1'b0;
               end
            end
            S_DATA: begin
               if (!tick_d) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  cnt_q   <= FULL_RELOAD;
                  shift_q <= {sample_bit, shift_q[DATA_BITS-1:1]};
                  par_q   <= par_q ^ sample_bit;
                  if (bits_q != '0) begin
                     bits_q <= bits_q - 1'b1;
                  end else if (PARITY != 0) begin
                     state_q <= S_PAR;
                  end else begin
                     state_q <= S_STOP;
                     bits_q  <= 4'(STOP_BITS - 1);
                  end
               end
            end
            S_PAR: begin
               if (!tick_d) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  // Odd mode expects data XOR parity bit to be 1.
                  perr_q  <= ((par_q ^ sample_bit) != (PARITY == 2));
                  cnt_q   <= FULL_RELOAD;
                  state_q <= S_STOP;
                  bits_q  <= 4'(STOP_BITS - 1);
               end
            end
            S_STOP: begin
               if (!tick_d) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  cnt_q <= FULL_RELOAD;
                  if (bits_q != '0) begin
                     ferr_q <= stop_fe_d;
                     bits_q <= bits_q - 1'b1;
                  end else begin
                     // Back to IDLE mid stop bit so a back-to-back start edge is seen.
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     if (!valid_q || m_if.out_ready) begin
                        data_q  <= shift_q;
                        fe_q    <= stop_fe_d;
                        pe_q    <= perr_q;
                        valid_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign m_if.out_data   = data_q;
   assign m_if.out_valid  = valid_q;
   assign m_if.frame_err  = fe_q;
   assign m_if.parity_err = pe_q;
   assign overrun         = overrun_q;
   assign busy            = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param
// dut0: default 8N1 at 435 clk/bit; dut1: even parity at 16 clk/bit.
module tb_uart_rx_param;
   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic reset;
   logic rx0, rx1;
   logic ovr0, ovr1, busy0, busy1;
   int   checks = 0;
   int   errors = 0;
   int   ovr_cnt0 = 0;
   int   ovr_cnt1 = 0;
   logic busy_seen1 = 1'b0;
   logic [9:0] q0[$];
   logic [9:0] q1[$];

   uart_rx_param_if #(.DATA_BITS(8)) if0 ();
   uart_rx_param_if #(.DATA_BITS(8)) if1 ();

   uart_rx_param dut0 (
      .clk(clk), .reset(reset), .uart_in(rx0), .m_if(if0.master),
      .overrun(ovr0), .busy(busy0)
   );

   uart_rx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .reset(reset), .uart_in(rx1), .m_if(if1.master),
      .overrun(ovr1), .busy(busy1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (if0.out_valid && if0.out_ready) begin
            if (q0.size() == 0) chk("dut0_extra_word", {if0.parity_err, if0.frame_err, if0.out_data}, 32'hFFFF);
            else                chk("dut0_word", {if0.parity_err, if0.frame_err, if0.out_data}, q0.pop_front());
         end
         if (if1.out_valid && if1.out_ready) begin
            if (q1.size() == 0) chk("dut1_extra_word", {if1.parity_err, if1.frame_err, if1.out_data}, 32'hFFFF);
            else                chk("dut1_word", {if1.parity_err, if1.frame_err, if1.out_data}, q1.pop_front());
         end
         if (ovr0)  ovr_cnt0++;
         if (ovr1)  ovr_cnt1++;
         if (busy1) busy_seen1 = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_bits(input int which, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (which == 0) begin
            rx0 = bits[i];
            repeat (435) tick();
         end else begin
            rx1 = bits[i];
            repeat (16) tick();
         end
      end
   endtask

   // Even-parity frame for dut1; bad flips the parity bit.
   task automatic send1(input logic [7:0] data, input logic bad, input logic expect_word);
      logic pbit;
      pbit = (^data) ^ bad;
      if (expect_word) q1.push_back({bad, 1'b0, data});
      send_bits(1, {5'b0, 1'b1, pbit, data, 1'b0}, 11);
   endtask

   task automatic drain(input int which, input int limit);
      int n;
      n = 0;
      while (((which == 0) ? q0.size() : q1.size()) != 0 && n < limit) begin
         tick();
         n++;
      end
      chk((which == 0) ? "dut0_drain" : "dut1_drain", (which == 0) ? q0.size() : q1.size(), 0);
   endtask

   initial begin
      rx0 = 1'b1;
      rx1 = 1'b1;
      if0.out_ready = 1'b1;
      if1.out_ready = 1'b1;
      reset = 1'b1;
      #11 reset = 1'b0;
      #100 reset = 1'b1;
      #5;
      chk("rst_valid0", if0.out_valid, 0);
      chk("rst_data0",  if0.out_data, 0);
      chk("rst_busy0",  busy0, 0);
      chk("rst_ovr0",   ovr0, 0);
      chk("rst_valid1", if1.out_valid, 0);
      #6 reset = 1'b0;
      repeat (5) tick();

      // Test 1: default 8N1, word 0xFD
      q0.push_back({2'b00, 8'hFD});
      send_bits(0, {6'b0, 1'b1, 8'hFD, 1'b0}, 10);
      drain(0, 200);

      // Test 2: even parity, bad then good parity bit
      send1(8'h41, 1'b1, 1'b1);
      send1(8'h41, 1'b0, 1'b1);
      drain(1, 100);

      // Test 3: consumer stalled, second frame overruns
      if1.out_ready = 1'b0;
      send1(8'h12, 1'b0, 1'b1);
      send1(8'h34, 1'b0, 1'b0);
      repeat (20) tick();
      chk("ovr_pulse", ovr_cnt1, 1);
      chk("held_valid", if1.out_valid, 1);
      chk("held_data", if1.out_data, 8'h12);
      if1.out_ready = 1'b1;
      tick();
      tick();
      chk("valid_fall", if1.out_valid, 0);
      drain(1, 10);
      send1(8'h56, 1'b0, 1'b1);
      drain(1, 100);

      // Test 4: back-to-back with ready held high
      send1(8'hAA, 1'b0, 1'b1);
      send1(8'h55, 1'b0, 1'b1);
      drain(1, 100);
      chk("no_overrun_b2b", ovr_cnt1, 1);

      // Test 5a: short glitch is a false start
      busy_seen1 = 1'b0;
      repeat (5) tick();
      rx1 = 1'b0;
      #100 rx1 = 1'b1;
      repeat (40) tick();
      chk("glitch_busy_seen", busy_seen1, 1);
      chk("glitch_idle", busy1, 0);
      chk("glitch_no_word", if1.out_valid, 0);

      // Test 5b: reset in the middle of a data bit
      send_bits(1, 16'b0000_0000_0000_1010, 4);
      repeat (8) tick();
      chk("pre_rst_busy", busy1, 1);
      reset = 1'b1;
      rx1 = 1'b1;
      #1;
      chk("mid_rst_busy", busy1, 0);
      chk("mid_rst_valid", if1.out_valid, 0);
      chk("mid_rst_flags", {if1.frame_err, if1.parity_err, ovr1}, 0);
      chk("mid_rst_data", if1.out_data, 0);
      #50 reset = 1'b0;
      repeat (5) tick();
      send1(8'h3C, 1'b0, 1'b1);
      drain(1, 100);

      // Test 6: break condition then a clean frame
      q1.push_back({2'b01, 8'h00});
      rx1 = 1'b0;
      repeat (20 * 16) tick();
      rx1 = 1'b1;
      repeat (40) tick();
      chk("break_one_frame", q1.size(), 0);
      send1(8'h7E, 1'b0, 1'b1);
      drain(1, 100);

      repeat (20) tick();
      chk("final_ovr0", ovr_cnt0, 0);
      chk("final_ovr1", ovr_cnt1, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver that sits behind `uart_in` in `top`. It is configurable in bit period, data width, parity mode and stop-bit count. It delivers each frame through a one-entry ready/valid holding register, with per-frame framing and parity error flags and an overrun pulse. It sits between the board RX pin and the puzzle-solver cores.

Parameters:
- CLK_DIV, 435, clocks per bit. 435 gives 57471 baud at 25 MHz. Legal range is 4 or more.
- DATA_BITS, 8, data bits per frame. Legal range is 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits checked: 1 or 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- uart_in  in  1  serial line, idle high, asynchronous to clk
- out_data  out  DATA_BITS  received word, LSB = first data bit
- out_valid  out  1  holding register full
- out_ready  in  1  consumer accepts the word on a clk edge where out_valid=1
- frame_err  out  1  a stop bit sampled 0; qualified by out_valid
- parity_err  out  1  parity mismatch; qualified by out_valid; always 0 when PARITY=0
- overrun  out  1  one-cycle pulse: a completed frame was dropped
- busy  out  1  high in every state except IDLE

Behaviour:
Interface: one clock; reset is asynchronous and active-high.

Reset:
- Entering reset at any time, including mid-frame, forces: state IDLE; all outputs 0; out_data 0; the synchroniser flops to 1.

Input path:
- uart_in passes through a 2-flop synchroniser; rxs is the output of the second flop.
- Start detection uses a registered copy of rxs (rxs_d).
- A start is detected only on a falling edge, rxs_d=1 and rxs=0. A line held low therefore never re-triggers.

State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: on a falling edge, load the bit counter and go to START. Call that cycle T0.
- START: at T0 + CLK_DIV/2 (integer division), sample rxs.
  - If rxs=1: false start; return to IDLE with no flags and no output.
  - Otherwise go to DATA.
- DATA: sample at T0 + CLK_DIV/2 + k*CLK_DIV for k = 1..DATA_BITS.
  - Shift right into the shift register, LSB first.
  - Keep a running XOR of the data bits.
- PARITY (only when PARITY != 0): one sample, taken one bit period after the last data sample.
  - Error when XOR(data, parity bit) is not 0 for even mode, or not 1 for odd mode.
- STOP: STOP_BITS samples, spaced CLK_DIV apart.
  - frame_err is set if any stop sample is 0.
  - After the last stop sample, go to IDLE in the same cycle. This re-arms the receiver half a bit early for back-to-back frames.
- The bit-period counter is $clog2(CLK_DIV) bits wide and counts down. A sample fires when it reaches 0, then it reloads CLK_DIV-1.

Delivery:
- The cycle after the last stop sample is called D. At D the completed frame is offered to the holding register.
- Case: out_valid=0, or out_valid=1 and out_ready=1 on that same edge. Load out_data, frame_err and parity_err; out_valid is 1 after the edge. Simultaneous consume and load gives no overrun and no gap in out_valid.
- Case: out_valid=1 and out_ready=0. The new frame is discarded, the held word and its flags are unchanged, and overrun pulses for exactly one cycle.
- Consume without a new frame (out_valid=1 and out_ready=1): out_valid goes to 0 on that edge.
- out_data, frame_err and parity_err stay stable while out_valid=1 and the word is not consumed.
- Frames that have errors are still delivered; the consumer decides what to do with them.

Latency:
- uart_in falling to T0: 2–3 clk.
- Last stop sample to out_valid high: 1 clk.

Break condition (line held low):
- Produces exactly one frame with out_data=0 and frame_err=1.
- Nothing further is received until the line has returned high and then fallen again.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each sample point (start, data, parity, stop) takes the majority of rxs at the sample cycle and the two preceding cycles. This is a 3-tap shift register, and CLK_DIV must be 8 or more. The sample cycle and all latencies are unchanged.
- Not defined: single sample of rxs at the sample cycle, with no extra flops.

Test Plan:
1. Defaults. Hold reset high for 11 ns, low, then high for 11 ns again, mid-idle. Drive the frame: start (17400 ns low), bit0=1, bit1=0, rest high. Result: out_valid rises once, out_data=0xFD, frame_err=0, parity_err=0, overrun=0.
2. PARITY=1. Send 0x41 with parity bit 1 -> parity_err=1. Send it again with parity bit 0 -> parity_err=0, out_data=0x41 both times.
3. out_ready held 0. Send 0x12 then 0x34 back-to-back -> out_data stays 0x12 and overrun pulses 1 cycle at the second D. Raise out_ready -> out_valid falls; the next frame 0x56 is delivered normally.
4. out_ready held 1. Send back-to-back frames 0xAA, 0x55 with no idle between them -> both delivered in order, each out_valid lasts 1 cycle, no overrun.
5. Glitch: drive uart_in low for 100 ns in idle -> busy pulses, then returns to IDLE, with no out_valid. Assert reset mid-data-bit of a frame -> all outputs are 0 immediately; the next full frame 0x3C is received correctly.
6. Break: hold uart_in low for 20 bit times -> exactly one frame with out_data=0x00 and frame_err=1. Release high, then send 0x7E -> received without error.
